// File: rtl/plugboard_pkg.sv
// Shared encodings for the programmable plugboard: programming ops, status codes,
// controller states and a one-hot test used on both the lookup and programming paths.
package plugboard_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_REMOVE = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ERR_OK          = 3'd0,
    ERR_BAD_ONEHOT  = 3'd1,
    ERR_SAME_LETTER = 3'd2,
    ERR_A_PLUGGED   = 3'd3,
    ERR_B_PLUGGED   = 3'd4,
    ERR_FULL        = 3'd5,
    ERR_NOT_FOUND   = 3'd6,
    ERR_BAD_OP      = 3'd7
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITE,
    ST_CLEAR,
    ST_RESP
  } state_e;

  // Widest alphabet the one-hot helper accepts; callers zero-extend into it.
  localparam int MAX_LETTERS = 64;

  function automatic logic is_onehot(input logic [MAX_LETTERS-1:0] v);
    return (v != '0) && ((v & (v - MAX_LETTERS'(1))) == '0);
  endfunction

endpackage

// File: rtl/plugboard_match.sv
// Combinational search of one letter against every valid plug slot; reports
// whether it is plugged, in which slot, and the letter it is wired to.
module plugboard_match #(
  parameter int LETTERS   = 26,
  parameter int MAX_PAIRS = 10,
  parameter int IDX_W     = 4
) (
  input  logic [LETTERS-1:0]   letter,
  input  logic [LETTERS-1:0]   slot_a [MAX_PAIRS],
  input  logic [LETTERS-1:0]   slot_b [MAX_PAIRS],
  input  logic [MAX_PAIRS-1:0] slot_valid,
  output logic                 hit,
  output logic [IDX_W-1:0]     idx,
  output logic [LETTERS-1:0]   partner
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    partner = '0;
    for (int i = 0; i < MAX_PAIRS; i++) begin
      if (slot_valid[i] && letter == slot_a[i]) begin
        hit     = 1'b1;
        idx     = IDX_W'(i);
        partner = slot_b[i];
      end else if (slot_valid[i] && letter == slot_b[i]) begin
        hit     = 1'b1;
        idx     = IDX_W'(i);
        partner = slot_a[i];
      end
    end
  end

endmodule

// File: rtl/plugboard_table.sv
// Programmable Enigma plugboard: slot table of reciprocal swaps, registered one-hot
// lookup, and a ready/valid programming port with a conflict-checking controller.
module plugboard_table
  import plugboard_pkg::*;
#(
  parameter int LETTERS   = 26,
  parameter int MAX_PAIRS = 10,
  parameter int CNT_W     = $clog2(MAX_PAIRS + 1)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [LETTERS-1:0] in_letter,
  output logic               out_valid,
  output logic [LETTERS-1:0] out_letter,
  output logic               out_bad,
  input  logic               prog_valid,
  output logic               prog_ready,
  input  logic [1:0]         prog_op,
  input  logic [LETTERS-1:0] prog_a,
  input  logic [LETTERS-1:0] prog_b,
  output logic               done,
  output logic [2:0]         err,
  output logic [CNT_W-1:0]   pair_count
);

  localparam int IDX_W = (MAX_PAIRS > 1) ? $clog2(MAX_PAIRS) : 1;

  state_e state, state_nx;
  op_e    cap_op;
  err_e   err_q, check_err;

  logic [LETTERS-1:0]   cap_a, cap_b;
  logic [LETTERS-1:0]   slot_a [MAX_PAIRS];
  logic [LETTERS-1:0]   slot_b [MAX_PAIRS];
  logic [MAX_PAIRS-1:0] slot_valid;
  logic [IDX_W-1:0]     clr_idx, free_idx;
  logic                 accept, lk_onehot, a_onehot, b_onehot;

  logic               lk_hit, a_hit, b_hit;
  logic [IDX_W-1:0]   lk_idx, a_idx, b_idx;
  logic [LETTERS-1:0] lk_partner, a_partner, b_partner;
  logic               unused_match;

  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_PAIRS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_PAIRS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  plugboard_match #(.LETTERS(LETTERS), .MAX_PAIRS(MAX_PAIRS), .IDX_W(IDX_W)) u_match_lookup (
    .letter(in_letter), .slot_a(slot_a), .slot_b(slot_b), .slot_valid(slot_valid),
    .hit(lk_hit), .idx(lk_idx), .partner(lk_partner)
  );

  plugboard_match #(.LETTERS(LETTERS), .MAX_PAIRS(MAX_PAIRS), .IDX_W(IDX_W)) u_match_a (
    .letter(cap_a), .slot_a(slot_a), .slot_b(slot_b), .slot_valid(slot_valid),
    .hit(a_hit), .idx(a_idx), .partner(a_partner)
  );

  plugboard_match #(.LETTERS(LETTERS), .MAX_PAIRS(MAX_PAIRS), .IDX_W(IDX_W)) u_match_b (
    .letter(cap_b), .slot_a(slot_a), .slot_b(slot_b), .slot_valid(slot_valid),
    .hit(b_hit), .idx(b_idx), .partner(b_partner)
  );

  assign unused_match = ^{lk_idx, a_partner, b_idx, b_partner};

  assign lk_onehot = is_onehot(MAX_LETTERS'(in_letter));
  assign a_onehot  = is_onehot(MAX_LETTERS'(cap_a));
  assign b_onehot  = is_onehot(MAX_LETTERS'(cap_b));
  assign accept    = prog_valid && prog_ready;
  assign err       = done ? err_q : ERR_OK;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_letter <= '0;
      out_bad    <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      out_bad    <= in_valid && !lk_onehot;
      out_letter <= (!in_valid || !lk_onehot) ? '0 : (lk_hit ? lk_partner : in_letter);
    end
  end

  // Checks are ordered so the first failing rule decides the reported code.
  always_comb begin
    check_err = ERR_OK;
    if (cap_op == OP_RSVD)
      check_err = ERR_BAD_OP;
    else if (cap_op != OP_CLEAR && (!a_onehot || (cap_op == OP_ADD && !b_onehot)))
      check_err = ERR_BAD_ONEHOT;
    else if (cap_op == OP_ADD && cap_a == cap_b)
      check_err = ERR_SAME_LETTER;
    else if (cap_op == OP_ADD && a_hit)
      check_err = ERR_A_PLUGGED;
    else if (cap_op == OP_ADD && b_hit)
      check_err = ERR_B_PLUGGED;
    else if (cap_op == OP_ADD && pair_count == CNT_W'(MAX_PAIRS))
      check_err = ERR_FULL;
    else if (cap_op == OP_REMOVE && !a_hit)
      check_err = ERR_NOT_FOUND;
  end

  always_comb begin
    free_idx = '0;
    for (int i = MAX_PAIRS - 1; i >= 0; i--)
      if (!slot_valid[i]) free_idx = IDX_W'(i);
  end

  always_comb begin
    state_nx   = state;
    prog_ready = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        prog_ready = 1'b1;
        if (prog_valid) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        if (check_err != ERR_OK)  state_nx = ST_RESP;
        else if (cap_op == OP_CLEAR) state_nx = ST_CLEAR;
        else                      state_nx = ST_WRITE;
      end
      ST_WRITE: state_nx = ST_RESP;
      ST_CLEAR: if (clr_idx == IDX_W'(MAX_PAIRS - 1)) state_nx = ST_RESP;
      ST_RESP: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      slot_valid <= '0;
      pair_count <= '0;
      clr_idx    <= '0;
      err_q      <= ERR_OK;
      cap_op     <= OP_ADD;
      cap_a      <= '0;
      cap_b      <= '0;
    end else begin
      pair_count <= popcount(slot_valid);
      if (accept) begin
        cap_op <= op_e'(prog_op);
        cap_a  <= prog_a;
        cap_b  <= prog_b;
      end
      if (state == ST_CHECK) begin
        err_q   <= check_err;
        clr_idx <= '0;
      end
      if (state == ST_WRITE) begin
        if (cap_op == OP_ADD) slot_valid[free_idx] <= 1'b1;
        else                  slot_valid[a_idx]    <= 1'b0;
      end
      if (state == ST_CLEAR) begin
        slot_valid[clr_idx] <= 1'b0;
        clr_idx             <= clr_idx + IDX_W'(1);
      end
    end
  end

  // NOTE: slot letters carry no reset; the valid bits alone decide whether a slot is live.
  always_ff @(posedge CLOCK_50) begin
    if (state == ST_WRITE && cap_op == OP_ADD) begin
      slot_a[free_idx] <= cap_a;
      slot_b[free_idx] <= cap_b;
    end
  end

endmodule

// File: tb/tb_plugboard_table.sv
// Self-checking bench for plugboard_table: lookup scoreboard, table-driven lookup
// vectors, programming latency/status checks, CLEAR overlap and reset-abort sequences.
module tb_plugboard_table;
  import plugboard_pkg::*;

  localparam int LETTERS   = 26;
  localparam int MAX_PAIRS = 10;
  localparam int CNT_W     = $clog2(MAX_PAIRS + 1);

  logic               CLOCK_50 = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic [LETTERS-1:0] in_letter = '0;
  logic               out_valid;
  logic [LETTERS-1:0] out_letter;
  logic               out_bad;
  logic               prog_valid = 1'b0;
  logic               prog_ready;
  logic [1:0]         prog_op = 2'b00;
  logic [LETTERS-1:0] prog_a = '0;
  logic [LETTERS-1:0] prog_b = '0;
  logic               done;
  logic [2:0]         err;
  logic [CNT_W-1:0]   pair_count;

  plugboard_table #(.LETTERS(LETTERS), .MAX_PAIRS(MAX_PAIRS)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .in_valid(in_valid), .in_letter(in_letter),
    .out_valid(out_valid), .out_letter(out_letter), .out_bad(out_bad),
    .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_op(prog_op),
    .prog_a(prog_a), .prog_b(prog_b),
    .done(done), .err(err), .pair_count(pair_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [LETTERS-1:0] letter;
    logic               bad;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [LETTERS-1:0] in;
    logic [LETTERS-1:0] want;
    logic               bad;
  } vec_t;
  vec_t vecs[6];

  int partner[LETTERS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  function automatic logic [LETTERS-1:0] lt(input int i);
    logic [LETTERS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [LETTERS-1:0] model(input int i);
    return (partner[i] < 0) ? lt(i) : lt(partner[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LETTERS; i++) partner[i] = -1;
  endtask

  always @(posedge CLOCK_50) begin
    exp_t e;
    #1;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("lookup_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("lookup_letter", 32'(out_letter), 32'(e.letter));
        check("lookup_bad", 32'(out_bad), 32'(e.bad));
      end
    end
  end

  task automatic lookup(input logic [LETTERS-1:0] l, input logic [LETTERS-1:0] want, input logic bad);
    @(negedge CLOCK_50);
    in_valid  = 1'b1;
    in_letter = l;
    sb.push_back('{want, bad});
  endtask

  task automatic idle(input int cycles);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    repeat (cycles) @(negedge CLOCK_50);
  endtask

  task automatic lookup_all();
    for (int i = 0; i < LETTERS; i++) lookup(lt(i), model(i), 1'b0);
    idle(2);
  endtask

  // Drives one request, measures done latency in cycles after the accept edge.
  task automatic prog(input logic [1:0] op, input logic [LETTERS-1:0] a, input logic [LETTERS-1:0] b,
                      input logic [2:0] want_err, input int want_lat, input int want_cnt);
    int n;
    @(negedge CLOCK_50);
    check("prog_ready_idle", 32'(prog_ready), 32'd1);
    prog_valid = 1'b1;
    prog_op    = op;
    prog_a     = a;
    prog_b     = b;
    @(negedge CLOCK_50);
    prog_valid = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("done_latency", 32'(n), 32'(want_lat));
    check("done_err", 32'(err), 32'(want_err));
    @(negedge CLOCK_50);
    check("done_pulse_width", 32'(done), 32'd0);
    check("pair_count", 32'(pair_count), 32'(want_cnt));
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    int pulses;
    pulses = 0;
    repeat (cycles) begin
      @(negedge CLOCK_50);
      if (done) pulses++;
    end
    check(name, 32'(pulses), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();

    // Reset values.
    repeat (3) @(negedge CLOCK_50);
    check("rst_prog_ready", 32'(prog_ready), 32'd1);
    check("rst_pair_count", 32'(pair_count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_letter", 32'(out_letter), 32'd0);
    check("rst_out_bad", 32'(out_bad), 32'd0);
    reset = 1'b0;

    lookup(lt(0), lt(0), 1'b0);
    idle(2);

    // ADD A<->B.
    prog(OP_ADD, lt(0), lt(1), ERR_OK, 3, 1);
    partner[0] = 1; partner[1] = 0;

    vecs[0] = '{lt(0),          lt(1),  1'b0};
    vecs[1] = '{lt(1),          lt(0),  1'b0};
    vecs[2] = '{lt(2),          lt(2),  1'b0};
    vecs[3] = '{lt(25),         lt(25), 1'b0};
    vecs[4] = '{'0,             '0,     1'b1};
    vecs[5] = '{lt(0) | lt(2),  '0,     1'b1};
    for (int i = 0; i < 6; i++) lookup(vecs[i].in, vecs[i].want, vecs[i].bad);
    idle(2);

    // Rejected requests leave the table unchanged.
    prog(OP_ADD,    lt(0), lt(2),          ERR_A_PLUGGED,   2, 1);
    prog(OP_ADD,    lt(2), lt(2),          ERR_SAME_LETTER, 2, 1);
    prog(OP_ADD,    '0,    lt(2),          ERR_BAD_ONEHOT,  2, 1);
    prog(OP_ADD,    lt(2), lt(0),          ERR_B_PLUGGED,   2, 1);
    prog(OP_RSVD,   '0,    '0,             ERR_BAD_OP,      2, 1);
    prog(OP_REMOVE, lt(3), '0,             ERR_NOT_FOUND,   2, 1);
    prog(OP_ADD,    lt(2), lt(0) | lt(3),  ERR_BAD_ONEHOT,  2, 1);
    lookup_all();

    // Fill all slots, then overflow.
    for (int i = 1; i < MAX_PAIRS; i++) begin
      prog(OP_ADD, lt(2 * i), lt(2 * i + 1), ERR_OK, 3, i + 1);
      partner[2 * i] = 2 * i + 1; partner[2 * i + 1] = 2 * i;
    end
    lookup_all();
    prog(OP_ADD, lt(20), lt(21), ERR_FULL, 2, MAX_PAIRS);

    // Remove E<->F by naming its second letter.
    prog(OP_REMOVE, lt(5), '0, ERR_OK, 3, MAX_PAIRS - 1);
    partner[4] = -1; partner[5] = -1;
    lookup_all();

    // CLEAR with a lookup every cycle; slot 0 holds A<->B, slot 3 holds G<->H.
    @(negedge CLOCK_50);
    check("clear_ready", 32'(prog_ready), 32'd1);
    prog_valid = 1'b1;
    prog_op    = OP_CLEAR;
    prog_a     = '0;
    prog_b     = '0;
    in_valid   = 1'b1;
    in_letter  = lt(0);
    sb.push_back('{lt(1), 1'b0});
    for (int n = 1; n <= 14; n++) begin
      @(negedge CLOCK_50);
      check("clear_done_timing", 32'(done), 32'(n == 12));
      if (n == 12) check("clear_err", 32'(err), 32'd0);
      if (n >= 4 && n <= 6) check("clear_busy_ready", 32'(prog_ready), 32'd0);
      prog_valid = (n >= 4 && n <= 6);
      prog_op    = OP_ADD;
      prog_a     = lt(20);
      prog_b     = lt(21);
      if (n % 2 == 1) begin
        in_letter = lt(6);
        sb.push_back('{(n <= 5) ? lt(7) : lt(6), 1'b0});
      end else begin
        in_letter = lt(0);
        sb.push_back('{(n <= 2) ? lt(1) : lt(0), 1'b0});
      end
    end
    prog_valid = 1'b0;
    idle(1);
    check("clear_pair_count", 32'(pair_count), 32'd0);
    expect_quiet(6, "clear_no_extra_done");
    model_reset();
    lookup_all();

    // Reset in CLEAR cycle 5 while slot 5 (K<->L) is still live.
    for (int i = 0; i < 6; i++) begin
      prog(OP_ADD, lt(2 * i), lt(2 * i + 1), ERR_OK, 3, i + 1);
    end
    @(negedge CLOCK_50);
    prog_valid = 1'b1;
    prog_op    = OP_CLEAR;
    for (int n = 1; n <= 6; n++) begin
      @(negedge CLOCK_50);
      prog_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("mid_rst_prog_ready", 32'(prog_ready), 32'd1);
    check("mid_rst_pair_count", 32'(pair_count), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_letter", 32'(out_letter), 32'd0);
    check("mid_rst_out_bad", 32'(out_bad), 32'd0);
    reset = 1'b0;
    expect_quiet(16, "mid_rst_no_done");
    check("mid_rst_count_after", 32'(pair_count), 32'd0);
    lookup(lt(10), lt(10), 1'b0);
    lookup(lt(11), lt(11), 1'b0);
    lookup(lt(0),  lt(0),  1'b0);
    idle(3);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plugboard_table.md
Name: plugboard_table

Overview:
Clocked, programmable Enigma plugboard and the parametrised successor of the fixed-pair plugboard changer. It holds up to MAX_PAIRS reciprocal letter swaps in a slot table, with a valid bit per slot. Letters are one-hot on LETTERS-bit buses, matching the rotor/reflector datapath. The block sits twice around rero: the front instance feeds front_plug_out and the rear instance feeds rear_plug_out. It adds a ready/valid programming port with add, remove and clear, a conflict-checking FSM, and a registered lookup path.

Parameters:
LETTERS, 26, alphabet size (one-hot bus width)
MAX_PAIRS, 10, number of pair slots
CNT_W, $clog2(MAX_PAIRS+1), width of pair_count (derived; do not override)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous active-high reset
in_valid  in  1  lookup request
in_letter  in  LETTERS  one-hot letter to map
out_valid  out  1  lookup result valid (in_valid delayed 1 cycle)
out_letter  out  LETTERS  mapped one-hot letter
out_bad  out  1  in_letter was not exactly one-hot
prog_valid  in  1  programming request
prog_ready  out  1  FSM idle and able to accept a request
prog_op  in  2  00 ADD, 01 REMOVE, 10 CLEAR, 11 reserved (returns BAD_OP)
prog_a  in  LETTERS  first letter (ADD, REMOVE)
prog_b  in  LETTERS  second letter (ADD only)
done  out  1  one-cycle completion pulse
err  out  3  status code, valid while done=1
pair_count  out  CNT_W  number of valid slots

Behaviour:
- Reset values. Every slot valid bit is 0, and pair_count=0. FSM goes to IDLE with prog_ready=1. done=0, err=0, out_valid=0, out_letter=0, out_bad=0.
- Reset mid-operation. Reset aborts any FSM state on the next edge and leaves the table empty.
- Lookup latency is 1 cycle, fully pipelined, with one request accepted per cycle.
  - If in_letter matches slot.a of a valid slot, out_letter=slot.b. If it matches slot.b, out_letter=slot.a. If no valid slot matches, out_letter=in_letter.
  - If in_letter is not one-hot (zero or multiple bits set), out_letter=0 and out_bad=1.
  - Lookups always use the committed table. A slot write or invalidate becomes visible to lookups issued in the cycle after the write edge.
- Handshake.
  - A request is accepted on an edge where prog_valid and prog_ready are both 1. prog_op, prog_a and prog_b are captured on that edge.
  - prog_ready is 1 only in IDLE. prog_valid while busy is ignored and not queued.
- FSM states: IDLE, CHECK, WRITE, CLEAR, RESP.
  - IDLE to CHECK on accept.
  - CHECK evaluates errors in this priority order: BAD_OP=7, BAD_ONEHOT=1 (prog_a, or prog_b for ADD), SAME_LETTER=2 (ADD with a==b), A_PLUGGED=3, B_PLUGGED=4, FULL=5 (ADD with pair_count==MAX_PAIRS), NOT_FOUND=6 (REMOVE and prog_a is in no valid slot).
  - A letter counts as "plugged" if it appears as a or b of any valid slot.
  - CHECK to RESP on any error. On success, CHECK goes to WRITE for ADD/REMOVE and to CLEAR for CLEAR.
  - WRITE for ADD stores (a,b) in the lowest-index free slot and sets its valid bit. WRITE for REMOVE clears the valid bit of the slot containing prog_a, whether as a or as b. WRITE to RESP.
  - CLEAR invalidates one slot per cycle, index 0 to MAX_PAIRS-1, and takes exactly MAX_PAIRS cycles, then goes to RESP. Lookups during CLEAR see a partially cleared table.
  - RESP asserts done=1 for one cycle with err (0=OK), then returns to IDLE.
- Latency from the accept edge T:
  - ADD/REMOVE success: done high in cycle T+3.
  - Any error: done high in cycle T+2, table unchanged.
  - CLEAR: done high in cycle T+2+MAX_PAIRS.
- pair_count is the registered popcount of the valid bits. It updates on the edge after the table changes.

Decomposition:
- Shared package plugboard_pkg holds:
  - op encodings (OP_ADD, OP_REMOVE, OP_CLEAR);
  - error codes (ERR_OK through ERR_BAD_OP);
  - the FSM state enum;
  - a one-hot check function.
- Sub-module plugboard_match: combinational, per-slot compare of one letter against all valid slots. It returns hit, slot index and the partner letter.
  - It is instantiated once for the lookup path.
  - It is instantiated twice in CHECK, once for prog_a and once for prog_b.

Test Plan:
- Reset, then lookup of A (bit0) -> out_letter=bit0 one cycle later; pair_count=0, prog_ready=1.
- ADD A<->B, done at T+3 with err=0 -> lookup A returns bit1, lookup B returns bit0, lookup C returns bit2; pair_count=1.
- With A<->B present, ADD A<->C -> err=3; ADD C<->C -> err=2; prog_a=0 -> err=1; in each case done at T+2 and the table is unchanged.
- Fill 10 disjoint pairs, then ADD an 11th pair -> err=5, pair_count=10. REMOVE by prog_b letter -> err=0, pair_count=9, and both letters of that pair now map to themselves.
- CLEAR with back-to-back lookups -> done exactly at T+12 with default parameters; slot 0 unmapped from cycle T+3; pair_count=0 afterwards. prog_valid asserted during CLEAR is ignored.
- Assert reset during CLEAR cycle 5 -> all outputs take reset values on the next edge, prog_ready=1, and no done pulse is produced.
